fetch_pipe: RTL

Parametrised pipelined Y86-64 fetch stage. It holds the F pipeline register (predicted PC), selects the fetch PC from the prediction and the M/W-stage redirects, and reads a byte-addressable instruction memory with a load port. It decodes instruction length, register IDs and valC, and predicts the next PC. Results are registered into the D pipeline register. Stall/bubble control comes from the pipeline control unit.

---
 rtl/fetch_pipe.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fetch_pipe.sv
// fetch_pipe: Y86-64 fetch stage with F (predicted PC) and D registers.
// Define FETCH_PERF_EN to add fetch/redirect/stall counters.
module fetch_pipe #(
  parameter int WORD_W = 64,
  parameter int IMEM_BYTES = 1024,
  parameter int ADDR_W = 10,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [7:0]        imem_wdata,
  input  logic              F_stall,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic [WORD_W-1:0] M_valA,
  input  logic [3:0]        W_icode,
  input  logic [WORD_W-1:0] W_valM,
  output logic [2:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [WORD_W-1:0] D_valC,
  output logic [WORD_W-1:0] D_valP,
  output logic [WORD_W-1:0] f_predPC,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_redirect,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [WORD_W-1:0] LIM = WORD_W'(IMEM_BYTES);
  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [WORD_W-1:0] valc;
    logic [WORD_W-1:0] valp;
  } d_t;

  localparam d_t BUBBLE = '{
    stat: 3'd1, icode: 4'h1, ifun: 4'h0,
    ra: RNONE, rb: RNONE, valc: '0, valp: '0
  };

  logic [7:0]        mem [IMEM_BYTES];
  logic [WORD_W-1:0] pred_q, pred_d;
  d_t                d_q, d_d, f_d;
  logic              halted_q, halted_d;
  logic              m_redir, w_redir;
  logic [WORD_W-1:0] f_pc;
  logic [WORD_W-1:0] ba [10];
  logic [9:0]        bok;
  logic [7:0]        bv [10];
  logic              is_irm, is_jc, is_r2, err;
  logic [3:0]        len;
  logic [63:0]       c64;

  // Program load port; a write is seen by fetch from the next cycle on.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  assign m_redir = (M_icode == 4'h7) && !M_Cnd;
  assign w_redir = (W_icode == 4'h9);

  always_comb begin
    f_pc = pred_q;
    if (m_redir) f_pc = M_valA;
    else if (w_redir) f_pc = W_valM;
  end

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      ba[k]  = f_pc + WORD_W'(k);
      bok[k] = ba[k] < LIM;
      bv[k]  = bok[k] ? mem[ba[k][ADDR_W-1:0]] : 8'h00;
    end
  end

  always_comb begin
    f_d = BUBBLE;
    f_d.icode = bok[0] ? bv[0][7:4] : 4'h1;
    f_d.ifun  = bok[0] ? bv[0][3:0] : 4'h0;
    is_irm = f_d.icode inside {4'h3, 4'h4, 4'h5};
    is_jc  = f_d.icode inside {4'h7, 4'h8};
    is_r2  = f_d.icode inside {4'h2, 4'h6, 4'hA, 4'hB};
    unique case (1'b1)
      is_irm:  len = 4'd10;
      is_jc:   len = 4'd9;
      is_r2:   len = 4'd2;
      default: len = 4'd1;
    endcase
    err = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (4'(k) < len && !bok[k]) err = 1'b1;
    end
    if (is_irm || is_r2) begin
      f_d.ra = bv[1][7:4];
      f_d.rb = bv[1][3:0];
    end
    c64 = '0;
    for (int k = 0; k < 8; k++) begin
      if (is_irm) c64[8*k +: 8] = bv[k+2];
      else if (is_jc) c64[8*k +: 8] = bv[k+1];
    end
    f_d.valc = WORD_W'(c64);
    f_d.valp = f_pc + WORD_W'(len);
    if (err) f_d.stat = 3'd3;
    else if (f_d.icode > 4'hB) f_d.stat = 3'd4;
    else if (f_d.icode == 4'h0) f_d.stat = 3'd2;
    else f_d.stat = 3'd1;
  end

  assign f_predPC = is_jc ? f_d.valc : f_d.valp;

  // Once halted, fetch freezes and D only accepts bubbles.
  always_comb begin
    pred_d = pred_q;
    if (!F_stall && !halted_q) pred_d = f_predPC;
    d_d = d_q;
    halted_d = halted_q;
    if (!D_stall) begin
      if (D_bubble || halted_q) begin
        d_d = BUBBLE;
      end else begin
        d_d = f_d;
        if (f_d.stat != 3'd1) halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q   <= RESET_PC;
      d_q      <= BUBBLE;
      halted_q <= 1'b0;
    end else begin
      pred_q   <= pred_d;
      d_q      <= d_d;
      halted_q <= halted_d;
    end
  end

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.valc;
  assign D_valP  = d_q.valp;
  assign halted  = halted_q;

`ifdef FETCH_PERF_EN
  logic [31:0] pf_q, pf_d, pr_q, pr_d, ps_q, ps_d;

  always_comb begin
    pf_d = pf_q + 32'(!D_stall && !D_bubble && !halted_q);
    pr_d = pr_q + 32'((m_redir || w_redir) && (f_pc != pred_q));
    ps_d = ps_q + 32'(F_stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_q <= '0;
      pr_q <= '0;
      ps_q <= '0;
    end else begin
      pf_q <= pf_d;
      pr_q <= pr_d;
      ps_q <= ps_d;
    end
  end

  assign perf_fetched  = pf_q;
  assign perf_redirect = pr_q;
  assign perf_stall    = ps_q;
`endif

endmodule
